// File: rtl/alarm_set_ctrl.sv
// Alarm-set controller: debounced buttons, BCD MM:SS alarm entry, match detect and ring timer.
// Optional snooze on inc while ringing is enabled by defining SNOOZE_EN.
module alarm_set_ctrl #(
    parameter int DEB_CYCLES = 500000,
    parameter int RING_SECS  = 30,
    parameter int SNOOZE_MIN = 5
) (
    input  logic       clk50,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       tick_1hz,
    input  logic [7:0] cur_min,
    input  logic [7:0] cur_sec,
    output logic [7:0] alm_min,
    output logic [7:0] alm_sec,
    output logic       edit_min,
    output logic       edit_sec,
    output logic       alarm_on,
    output logic       buzz
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam int RW = $clog2(RING_SECS + 1);

    typedef enum logic [2:0] {IDLE, SET_MIN, SET_SEC, ARMED, RINGING} state_t;

    logic [2:0]    sync1, sync2, level, press;
    logic [CW-1:0] cnt [3];
    state_t        state;
    logic [RW-1:0] ring_cnt;
    logic          match_q, match_prev;
    logic          p_mode, p_inc, p_dec;

    // Bit order for all per-button vectors: [0] mode, [1] inc, [2] dec.
    // NOTE: every flop below uses non-blocking assignment so all registers update from pre-edge values.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            press <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            sync1 <= {btn_dec, btn_inc, btn_mode};
            sync2 <= sync1;
            press <= '0;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] != level[i]) begin
                    if (cnt[i] == CW'(DEB_CYCLES - 1)) begin
                        level[i] <= sync2[i];
                        press[i] <= sync2[i];
                        cnt[i]   <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    // Simultaneous inc and dec cancel each other; mode priority is applied in the FSM.
    assign p_mode = press[0];
    assign p_inc  = press[1] & ~press[2];
    assign p_dec  = press[2] & ~press[1];

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) return {(v[7:4] == 4'd5) ? 4'd0 : v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0) return {(v[7:4] == 4'd0) ? 4'd5 : v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

`ifdef SNOOZE_EN
    function automatic logic [7:0] bcd_snooze(input logic [7:0] v);
        int b;
        b = (int'(v[7:4]) * 10 + int'(v[3:0]) + SNOOZE_MIN) % 60;
        return {4'(b / 10), 4'(b % 10)};
    endfunction
`endif

    // Output flags {edit_min, edit_sec, alarm_on, buzz} for a given state.
    function automatic logic [3:0] flags(input state_t s);
        case (s)
            SET_MIN: return 4'b1000;
            SET_SEC: return 4'b0100;
            ARMED:   return 4'b0010;
            RINGING: return 4'b0011;
            default: return 4'b0000;
        endcase
    endfunction

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            alm_min    <= 8'h00;
            alm_sec    <= 8'h00;
            ring_cnt   <= '0;
            match_q    <= 1'b0;
            match_prev <= 1'b0;
            {edit_min, edit_sec, alarm_on, buzz} <= 4'b0000;
        end else begin
            match_q    <= (cur_min == alm_min) && (cur_sec == alm_sec);
            match_prev <= match_q;
            case (state)
                IDLE: begin
                    if (p_mode) begin
                        state <= SET_MIN;
                        {edit_min, edit_sec, alarm_on, buzz} <= flags(SET_MIN);
                    end
                end
                SET_MIN: begin
                    if (p_mode) begin
                        state <= SET_SEC;
                        {edit_min, edit_sec, alarm_on, buzz} <= flags(SET_SEC);
                    end else if (p_inc) alm_min <= bcd_inc(alm_min);
                    else if (p_dec)     alm_min <= bcd_dec(alm_min);
                end
                SET_SEC: begin
                    if (p_mode) begin
                        state <= ARMED;
                        {edit_min, edit_sec, alarm_on, buzz} <= flags(ARMED);
                    end else if (p_inc) alm_sec <= bcd_inc(alm_sec);
                    else if (p_dec)     alm_sec <= bcd_dec(alm_sec);
                end
                ARMED: begin
                    if (p_mode) begin
                        state <= IDLE;
                        {edit_min, edit_sec, alarm_on, buzz} <= flags(IDLE);
                    end else if (match_q && !match_prev) begin
                        state    <= RINGING;
                        ring_cnt <= '0;
                        {edit_min, edit_sec, alarm_on, buzz} <= flags(RINGING);
                    end
                end
                RINGING: begin
                    // Dismiss outranks a same-cycle tick; the partial count is simply dropped.
                    if (p_mode) begin
                        state <= ARMED;
                        {edit_min, edit_sec, alarm_on, buzz} <= flags(ARMED);
`ifdef SNOOZE_EN
                    end else if (p_inc) begin
                        alm_min <= bcd_snooze(alm_min);
                        state   <= ARMED;
                        {edit_min, edit_sec, alarm_on, buzz} <= flags(ARMED);
`endif
                    end else if (tick_1hz) begin
                        if (ring_cnt + 1'b1 == RW'(RING_SECS)) begin
                            state <= ARMED;
                            {edit_min, edit_sec, alarm_on, buzz} <= flags(ARMED);
                        end else begin
                            ring_cnt <= ring_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    {edit_min, edit_sec, alarm_on, buzz} <= flags(IDLE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_set_ctrl.sv
// Directed bench for alarm_set_ctrl with DEB_CYCLES=4, RING_SECS=3; snooze checks follow SNOOZE_EN.
module tb_alarm_set_ctrl;

    logic       clk50 = 1'b0;
    logic       reset;
    logic       btn_mode, btn_inc, btn_dec, tick_1hz;
    logic [7:0] cur_min, cur_sec;
    logic [7:0] alm_min, alm_sec;
    logic       edit_min, edit_sec, alarm_on, buzz;

    int n_cmp = 0;
    int n_err = 0;

    // Expected flag sets {edit_min, edit_sec, alarm_on, buzz}
    localparam logic [3:0] F_ID = 4'b0000, F_SM = 4'b1000, F_SS = 4'b0100,
                           F_AR = 4'b0010, F_RG = 4'b0011;
    localparam int B_MODE = 0, B_INC = 1, B_DEC = 2, B_BOTH = 3;

    typedef struct {
        int         btn;
        int         reps;
        logic [7:0] mn;
        logic [7:0] sc;
        logic [3:0] fl;
    } vec_t;

    vec_t vecs[17];

    alarm_set_ctrl #(.DEB_CYCLES(4), .RING_SECS(3), .SNOOZE_MIN(5)) dut (
        .clk50(clk50), .reset(reset),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .tick_1hz(tick_1hz), .cur_min(cur_min), .cur_sec(cur_sec),
        .alm_min(alm_min), .alm_sec(alm_sec),
        .edit_min(edit_min), .edit_sec(edit_sec),
        .alarm_on(alarm_on), .buzz(buzz)
    );

    always #5 clk50 = ~clk50;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk50);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] obs();
        return {12'h0, alm_min, alm_sec, edit_min, edit_sec, alarm_on, buzz};
    endfunction

    function automatic logic [31:0] want(input logic [7:0] mn, input logic [7:0] sc,
                                         input logic [3:0] fl);
        return {12'h0, mn, sc, fl};
    endfunction

    // A clean press: hold well past the debounce window, then release equally long.
    task automatic press(input int btn, input int reps = 1);
        repeat (reps) begin
            btn_mode = (btn == B_MODE);
            btn_inc  = (btn == B_INC) || (btn == B_BOTH);
            btn_dec  = (btn == B_DEC) || (btn == B_BOTH);
            step(10);
            btn_mode = 1'b0;
            btn_inc  = 1'b0;
            btn_dec  = 1'b0;
            step(10);
        end
    endtask

    task automatic tick_pulse();
        tick_1hz = 1'b1;
        step(1);
        tick_1hz = 1'b0;
        step(2);
    endtask

    function automatic vec_t mk(input int btn, input int reps, input logic [7:0] mn,
                                input logic [7:0] sc, input logic [3:0] fl);
        vec_t v;
        v.btn = btn; v.reps = reps; v.mn = mn; v.sc = sc; v.fl = fl;
        return v;
    endfunction

    logic [7:0] snz_min;
    logic [3:0] snz_fl;

    initial begin
        // Table starts in SET_MIN at 01:00 (left there by the debounce test).
        vecs[0]  = mk(B_INC,  1, 8'h02, 8'h00, F_SM);
        vecs[1]  = mk(B_MODE, 1, 8'h02, 8'h00, F_SS);
        vecs[2]  = mk(B_DEC,  1, 8'h02, 8'h59, F_SS);
        vecs[3]  = mk(B_MODE, 1, 8'h02, 8'h59, F_AR);
        vecs[4]  = mk(B_INC,  1, 8'h02, 8'h59, F_AR);
        vecs[5]  = mk(B_MODE, 1, 8'h02, 8'h59, F_ID);
        vecs[6]  = mk(B_INC,  1, 8'h02, 8'h59, F_ID);
        vecs[7]  = mk(B_MODE, 1, 8'h02, 8'h59, F_SM);
        vecs[8]  = mk(B_INC,  7, 8'h09, 8'h59, F_SM);
        vecs[9]  = mk(B_INC,  1, 8'h10, 8'h59, F_SM);
        vecs[10] = mk(B_DEC,  1, 8'h09, 8'h59, F_SM);
        vecs[11] = mk(B_DEC,  7, 8'h02, 8'h59, F_SM);
        vecs[12] = mk(B_MODE, 1, 8'h02, 8'h59, F_SS);
        vecs[13] = mk(B_INC,  1, 8'h02, 8'h00, F_SS);
        vecs[14] = mk(B_DEC,  1, 8'h02, 8'h59, F_SS);
        vecs[15] = mk(B_BOTH, 1, 8'h02, 8'h59, F_SS);
        vecs[16] = mk(B_MODE, 1, 8'h02, 8'h59, F_AR);

        reset = 1'b1;
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; tick_1hz = 1'b0;
        cur_min = 8'h00; cur_sec = 8'h00;
        step(3);
        check("reset_state", obs(), want(8'h00, 8'h00, F_ID));
        reset = 1'b0;
        step(2);

        press(B_MODE);
        check("enter_set_min", obs(), want(8'h00, 8'h00, F_SM));

        // 3-cycle glitch sits just under the 4-sample window.
        btn_inc = 1'b1;
        step(3);
        btn_inc = 1'b0;
        step(15);
        check("glitch_rejected", obs(), want(8'h00, 8'h00, F_SM));

        // Real press: pulse at edge 6, alm_min visible after edge 7.
        btn_inc = 1'b1;
        step(6);
        check("press_not_early", {24'h0, alm_min}, 32'h00);
        step(1);
        check("press_latency", {24'h0, alm_min}, 32'h01);
        step(3);
        btn_inc = 1'b0;
        step(12);
        check("single_pulse", obs(), want(8'h01, 8'h00, F_SM));

        for (int i = 0; i < 17; i++) begin
            press(vecs[i].btn, vecs[i].reps);
            check($sformatf("vec%0d", i), obs(), want(vecs[i].mn, vecs[i].sc, vecs[i].fl));
        end

        // Ring and timeout, armed at 02:59.
        cur_min = 8'h02; cur_sec = 8'h59;
        step(1);
        check("ring_lat1", {31'h0, buzz}, 32'h0);
        step(1);
        check("ring_lat2", obs(), want(8'h02, 8'h59, F_RG));
        tick_pulse();
        tick_pulse();
        check("ring_after2", {31'h0, buzz}, 32'h1);
        tick_1hz = 1'b1;
        step(1);
        tick_1hz = 1'b0;
        check("ring_timeout", obs(), want(8'h02, 8'h59, F_AR));
        step(20);
        check("no_rering_held", obs(), want(8'h02, 8'h59, F_AR));

        // Re-arm the match edge, ring, leave one tick counted, then dismiss with a same-cycle tick.
        cur_min = 8'h00;
        step(3);
        cur_min = 8'h02;
        step(2);
        check("ring_again", {31'h0, buzz}, 32'h1);
        tick_pulse();
        btn_mode = 1'b1;
        step(6);
        check("dismiss_not_early", {31'h0, buzz}, 32'h1);
        tick_1hz = 1'b1;
        step(1);
        tick_1hz = 1'b0;
        check("dismiss_with_tick", obs(), want(8'h02, 8'h59, F_AR));
        step(3);
        btn_mode = 1'b0;
        step(12);
        check("no_rering_dismiss", obs(), want(8'h02, 8'h59, F_AR));

        // Counter restarts on entry: a fresh ring needs all three ticks.
        cur_min = 8'h00;
        step(3);
        cur_min = 8'h02;
        step(2);
        tick_pulse();
        tick_pulse();
        check("cnt_cleared", {31'h0, buzz}, 32'h1);
        tick_pulse();
        check("cnt_timeout", obs(), want(8'h02, 8'h59, F_AR));

        // Build 57:10 for the snooze scenario.
        cur_min = 8'h00; cur_sec = 8'h00;
        press(B_MODE, 2);
        press(B_DEC, 5);
        check("dec_min_wrap", obs(), want(8'h57, 8'h59, F_SM));
        press(B_MODE);
        press(B_INC, 11);
        press(B_MODE);
        check("armed_5710", obs(), want(8'h57, 8'h10, F_AR));
        cur_min = 8'h57; cur_sec = 8'h10;
        step(3);
        check("ring_5710", {31'h0, buzz}, 32'h1);
        press(B_INC);
`ifdef SNOOZE_EN
        snz_min = 8'h02;
        snz_fl  = F_AR;
`else
        snz_min = 8'h57;
        snz_fl  = F_RG;
`endif
        check("inc_in_ringing", obs(), want(snz_min, 8'h10, snz_fl));
        if (buzz) begin
            press(B_MODE);
            check("dismiss_after_inc", obs(), want(snz_min, 8'h10, F_AR));
        end

        // Reset in the middle of SET_SEC with an inc press half-debounced.
        cur_min = 8'h00; cur_sec = 8'h00;
        press(B_MODE, 3);
        check("in_set_sec", obs(), want(snz_min, 8'h10, F_SS));
        btn_inc = 1'b1;
        step(4);
        #2 reset = 1'b1;
        btn_inc = 1'b0;
        #1 check("reset_async", obs(), want(8'h00, 8'h00, F_ID));
        step(2);
        reset = 1'b0;
        step(15);
        check("reset_no_carry", obs(), want(8'h00, 8'h00, F_ID));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
